q_8_22: RTL and testbench

//  Sequential add-and-shift unsigned binary multiplier (alternative ASMD form).
//  - Controller FSM plus datapath: registers B, A, Q, carry C, bit counter P.
//  - Handshake is start/rdy. Product {A,Q} is valid whenever rdy is high.
//  - Standalone arithmetic unit; a host loads operands and waits for rdy.

---
 rtl/q_8_22.sv | 142 ++++++++++++++
 tb/tb_q_8_22.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/q_8_22.sv
// rtl/q_8_22.sv - sequential add-and-shift unsigned multiplier with start/rdy handshake
module q_8_22 #(
  parameter int DP_WIDTH = 5,
  parameter int BC_SIZE  = $clog2(DP_WIDTH + 1),
  parameter int ST_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  start,
  input  logic [DP_WIDTH-1:0]   multiplicand,
  input  logic [DP_WIDTH-1:0]   multiplier,
  output logic                  rdy,
  output logic [2*DP_WIDTH-1:0] product
);

  // State encoding; the fourth code is unused and falls back to idle.
  localparam logic [ST_WIDTH-1:0] S_IDLE  = ST_WIDTH'(0);
  localparam logic [ST_WIDTH-1:0] S_ADD   = ST_WIDTH'(1);
  localparam logic [ST_WIDTH-1:0] S_SHIFT = ST_WIDTH'(2);

  // Controller state
  logic [ST_WIDTH-1:0] state_q, state_d;
  logic [ST_WIDTH-1:0] state;
  logic [ST_WIDTH-1:0] next_state;

  // Control strobes from controller to datapath
  logic load_regs;
  logic decr_p;
  logic add_regs;
  logic shift_regs;
  logic zero;

  // Datapath registers
  logic [DP_WIDTH-1:0] b_q, b_d;
  logic [DP_WIDTH-1:0] a_q, a_d;
  logic [DP_WIDTH-1:0] q_q, q_d;
  logic                c_q, c_d;
  logic [BC_SIZE-1:0]  p_q, p_d;

  // Architectural views of the registers, kept under their well-known names
  logic [DP_WIDTH-1:0] B;
  logic [DP_WIDTH-1:0] A;
  logic [DP_WIDTH-1:0] Q;
  logic                C;
  logic [BC_SIZE-1:0]  P;

  assign state = state_q;
  assign B     = b_q;
  assign A     = a_q;
  assign Q     = q_q;
  assign C     = c_q;
  assign P     = p_q;

  // The counter is decremented in S_ADD, so in S_SHIFT zero means the last bit
  // has just been processed.
  assign zero    = (P == '0);
  assign product = {A, Q};
  assign state_d = next_state;

  // Next-state logic of the controller
  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE:  next_state = start ? S_ADD : S_IDLE;
      S_ADD:   next_state = S_SHIFT;
      S_SHIFT: next_state = zero ? S_IDLE : S_ADD;
      default: next_state = S_IDLE;
    endcase
  end

  // Controller outputs: rdy depends on state only, strobes may depend on inputs
  always_comb begin
    rdy        = 1'b0;
    load_regs  = 1'b0;
    decr_p     = 1'b0;
    add_regs   = 1'b0;
    shift_regs = 1'b0;
    case (state)
      S_IDLE: begin
        rdy       = 1'b1;
        load_regs = start;
      end
      S_ADD: begin
        decr_p   = 1'b1;
        add_regs = Q[0];
      end
      S_SHIFT: begin
        shift_regs = 1'b1;
      end
      default: begin
        rdy = 1'b0;
      end
    endcase
  end

  // Datapath next values: load operands, add partial product, shift right
  always_comb begin
    b_d = B;
    a_d = A;
    q_d = Q;
    c_d = C;
    p_d = P;
    if (load_regs) begin
      b_d = multiplicand;
      q_d = multiplier;
      a_d = '0;
      c_d = 1'b0;
      p_d = BC_SIZE'(DP_WIDTH);
    end
    if (decr_p) begin
      p_d = P - BC_SIZE'(1);
    end
    if (add_regs) begin
      // Carry out of the add lands in C and is shifted into A next cycle.
      {c_d, a_d} = {1'b0, A} + {1'b0, B};
    end
    if (shift_regs) begin
      // C ends up 0 after the shift because a zero is shifted in above it.
      {c_d, a_d, q_d} = {1'b0, C, A, Q[DP_WIDTH-1:1]};
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      b_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      c_q     <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      a_q     <= a_d;
      q_q     <= q_d;
      c_q     <= c_d;
      p_q     <= p_d;
    end
  end

endmodule

// File: tb/tb_q_8_22.sv
// tb/tb_q_8_22.sv - scoreboard bench for the add-and-shift multiplier q_8_22
module tb_q_8_22;

  logic       clk;
  logic       rst_b;
  logic       start;
  logic [4:0] multiplicand;
  logic [4:0] multiplier;
  logic       rdy;
  logic [9:0] product;

  int n_checks;
  int n_errors;
  logic [9:0] sb[$];

  q_8_22 dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .rdy          (rdy),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits at negedges until rdy is high; returns number of low cycles seen.
  task automatic wait_rdy(output int cnt);
    cnt = 0;
    while (rdy !== 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    if (rdy !== 1'b1) check("rdy_timeout", 0, 1);
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check(tag, product, e);
    end
  endtask

  task automatic do_mult(input logic [4:0] a, input logic [4:0] b, input bit mid_change);
    int cnt;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    sb.push_back(10'(a) * 10'(b));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (mid_change) begin
      multiplicand = 5'd1;
      multiplier   = 5'd0;
    end
    wait_rdy(cnt);
    check("latency", cnt, 10);
    pop_check("product");
  endtask

  initial begin
    int cnt;
    n_checks     = 0;
    n_errors     = 0;
    rst_b        = 1'b0;
    start        = 1'b0;
    multiplicand = 5'd0;
    multiplier   = 5'd0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_rdy", rdy, 1);
    check("rst_product", product, 0);
    check("rst_state", dut.state, 0);
    check("rst_p", dut.P, 0);
    rst_b = 1'b1;

    // Directed products including the carry-heavy maximum and zero operands
    do_mult(5'd5, 5'd3, 1'b0);
    do_mult(5'd31, 5'd31, 1'b0);
    do_mult(5'd0, 5'd31, 1'b0);
    do_mult(5'd31, 5'd0, 1'b0);

    // Operand inputs changed while busy must not affect the result
    do_mult(5'd7, 5'd9, 1'b1);

    // Reset while in S_ADD aborts the operation
    @(negedge clk);
    multiplicand = 5'd12;
    multiplier   = 5'd13;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("abort_in_add", dut.state, 1);
    rst_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_rdy", rdy, 1);
    check("abort_product", product, 0);
    check("abort_state", dut.state, 0);
    rst_b = 1'b1;
    do_mult(5'd6, 5'd7, 1'b0);

    // Back-to-back sweep with start held high; new operands appear after each rdy rise
    @(negedge clk);
    multiplicand = 5'd0;
    multiplier   = 5'd0;
    start        = 1'b1;
    sb.push_back(10'd0);
    for (int k = 0; k < 1024; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("b2b_busy", rdy, 0);
      wait_rdy(cnt);
      pop_check("sweep_product");
      if (k < 1023) begin
        multiplicand = 5'((k + 1) / 32);
        multiplier   = 5'((k + 1) % 32);
        sb.push_back(10'((k + 1) / 32) * 10'((k + 1) % 32));
      end else begin
        start = 1'b0;
      end
    end

    @(negedge clk);
    check("final_idle", rdy, 1);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
